// File: rtl/grep_stream_ctrl.sv
// Stream controller for the grepsic matcher: parses a length/pattern header, then slides
// an N-byte window over the text and reports each literal match (with a one-byte wildcard).
module grep_stream_ctrl #(
   parameter int         PAT_MAX  = 8,
   parameter logic [7:0] WILDCARD = 8'h2E
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        match_valid,
   output logic [15:0] match_pos,
   output logic [7:0]  match_count,
   output logic        done,
   output logic        err
);

   // state   | meaning
   // S_LEN   | waiting for the pattern length byte N
   // S_PAT   | collecting N pattern bytes
   // S_TEXT  | sliding window compare over text bytes
   // S_DRAIN | malformed header, discarding bytes until in_last
   // S_DONE  | one-cycle end-of-job pulse, in_ready low
   localparam logic [2:0] S_LEN   = 3'd0;
   localparam logic [2:0] S_PAT   = 3'd1;
   localparam logic [2:0] S_TEXT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int LW = $clog2(PAT_MAX + 1);

   logic [2:0]              state;
   logic [LW-1:0]           pat_len;
   logic [LW-1:0]           pat_cnt;
   logic [LW-1:0]           fill;
   logic [15:0]             txt_idx;
   logic [PAT_MAX-1:0][7:0] pat_sh;
   logic [PAT_MAX-1:0][7:0] pat_nxt;
   logic [PAT_MAX-1:0][7:0] hist;
   logic [PAT_MAX-1:0][7:0] hist_nxt;
   logic                    xfer;
   logic                    len_ok;
   logic                    win_eq;
   logic                    hit;

   assign in_ready = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign xfer     = in_valid & in_ready;
   assign len_ok   = (in_data != 8'd0) && (in_data <= 8'(PAT_MAX));

   // Both pattern and text shift in at element 0, so element j of each holds the byte
   // j positions back from the newest; aligning them needs no variable-offset indexing.
   assign pat_nxt  = {pat_sh[PAT_MAX-2:0], in_data};
   assign hist_nxt = {hist[PAT_MAX-2:0], in_data};

   always_comb begin
      win_eq = 1'b1;
      for (int j = 0; j < PAT_MAX; j++) begin
         if ((j < int'(pat_len)) && (pat_sh[j] != WILDCARD) && (pat_sh[j] != hist_nxt[j]))
            win_eq = 1'b0;
      end
   end

   assign hit = xfer && (state == S_TEXT) && ((fill + LW'(1)) >= pat_len) && win_eq;

   always_ff @(posedge clk) begin
      if (xfer && (state == S_PAT))
         pat_sh <= pat_nxt;
      if (xfer && (state == S_TEXT))
         hist <= hist_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_LEN;
         pat_len     <= '0;
         pat_cnt     <= '0;
         fill        <= '0;
         txt_idx     <= '0;
         match_valid <= 1'b0;
         match_pos   <= '0;
         match_count <= '0;
         err         <= 1'b0;
      end else begin
         match_valid <= 1'b0;
         if (state == S_DONE) begin
            state <= S_LEN;
         end else if (xfer) begin
            case (state)
               S_LEN: begin
                  err         <= 1'b0;
                  match_count <= '0;
                  txt_idx     <= '0;
                  fill        <= '0;
                  pat_cnt     <= '0;
                  pat_len     <= in_data[LW-1:0];
                  if (!len_ok) begin
                     err   <= 1'b1;
                     state <= in_last ? S_DONE : S_DRAIN;
                  end else if (in_last) begin
                     err   <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_PAT;
                  end
               end
               S_PAT: begin
                  pat_cnt <= pat_cnt + LW'(1);
                  if (in_last) begin
                     err   <= 1'b1;
                     state <= S_DONE;
                  end else if (pat_cnt == (pat_len - LW'(1))) begin
                     state <= S_TEXT;
                  end
               end
               S_TEXT: begin
                  txt_idx <= txt_idx + 16'd1;
                  if (fill < pat_len)
                     fill <= fill + LW'(1);
                  if (hit) begin
                     match_valid <= 1'b1;
                     match_pos   <= txt_idx - 16'(pat_len) + 16'd1;
                     if (match_count != 8'hFF)
                        match_count <= match_count + 8'd1;
                  end
                  if (in_last)
                     state <= S_DONE;
               end
               S_DRAIN: begin
                  if (in_last)
                     state <= S_DONE;
               end
               default: state <= S_LEN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_grep_stream_ctrl.sv
// Directed bench for grep_stream_ctrl: header parsing, matching, errors, gaps,
// saturation/wrap and mid-job reset, with hand-computed expectations.
module tb_grep_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        match_valid;
   logic [15:0] match_pos;
   logic [7:0]  match_count;
   logic        done;
   logic        err;

   int n_vec = 0;
   int n_fail = 0;

   logic [15:0] mpos[$];
   logic [7:0]  mcnt[$];
   logic        mwd[$];
   logic        derr[$];
   int          done_n = 0;
   int          ready_low = 0;
   int          ready_bad = 0;
   logic [7:0]  jq[$];

   grep_stream_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .match_valid (match_valid),
      .match_pos   (match_pos),
      .match_count (match_count),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (match_valid === 1'b1) begin
            mpos.push_back(match_pos);
            mcnt.push_back(match_count);
            mwd.push_back(done);
         end
         if (done === 1'b1) begin
            done_n++;
            derr.push_back(err);
         end
         if (in_ready === done) ready_bad++;
         if (in_ready !== 1'b1) ready_low++;
      end
   end

   task automatic put(input logic [7:0] d, input logic l);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         n_vec++; n_fail++;
         $display("FAIL put_timeout: in_ready=%b, want 1", in_ready);
      end
   endtask

   task automatic send_q(input int gap);
      for (int i = 0; i < jq.size(); i++) begin
         put(jq[i], (i == jq.size() - 1));
         if (gap != 0) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_vec++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL rst_match_valid: got %b want 0", match_valid); end
      n_vec++; if (match_pos !== 16'd0) begin n_fail++; $display("FAIL rst_match_pos: got %0d want 0", match_pos); end
      n_vec++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL rst_match_count: got %0d want 0", match_count); end
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
      rst = 1'b0;
   endtask

   // 02 'a' 'b' + "xabab": matches end at text indices 2 and 4 -> pos 1 and 3
   task automatic test_basic(input int gap, input string nm);
      int b, bd, bdr;
      b = mpos.size(); bd = done_n; bdr = derr.size();
      jq = '{8'h02, 8'h61, 8'h62, 8'h78, 8'h61, 8'h62, 8'h61, 8'h62};
      send_q(gap);
      idle(3);
      n_vec++; if (mpos.size() - b != 2) begin n_fail++; $display("FAIL %s_nmatch: got %0d want 2", nm, mpos.size() - b); end
      if (mpos.size() - b >= 2) begin
         n_vec++; if (mpos[b] !== 16'd1) begin n_fail++; $display("FAIL %s_pos0: got %0d want 1", nm, mpos[b]); end
         n_vec++; if (mpos[b+1] !== 16'd3) begin n_fail++; $display("FAIL %s_pos1: got %0d want 3", nm, mpos[b+1]); end
         n_vec++; if (mcnt[b] !== 8'd1) begin n_fail++; $display("FAIL %s_cnt0: got %0d want 1", nm, mcnt[b]); end
         n_vec++; if (mcnt[b+1] !== 8'd2) begin n_fail++; $display("FAIL %s_cnt1: got %0d want 2", nm, mcnt[b+1]); end
         n_vec++; if (mwd[b] !== 1'b0) begin n_fail++; $display("FAIL %s_done_with_first: got %b want 0", nm, mwd[b]); end
         n_vec++; if (mwd[b+1] !== 1'b1) begin n_fail++; $display("FAIL %s_done_with_last: got %b want 1", nm, mwd[b+1]); end
      end
      n_vec++; if (done_n - bd != 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_n - bd); end
      if (derr.size() > bdr) begin
         n_vec++; if (derr[bdr] !== 1'b0) begin n_fail++; $display("FAIL %s_err_at_done: got %b want 0", nm, derr[bdr]); end
      end
      n_vec++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL %s_count_held: got %0d want 2", nm, match_count); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b want 0", nm, err); end
   endtask

   task automatic test_wildcard();
      int b;
      b = mpos.size();
      jq = '{8'h03, 8'h61, 8'h2E, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61};
      send_q(0);
      idle(3);
      n_vec++; if (mpos.size() - b != 3) begin n_fail++; $display("FAIL wild_nmatch: got %0d want 3", mpos.size() - b); end
      if (mpos.size() - b >= 3) begin
         for (int i = 0; i < 3; i++) begin
            n_vec++; if (mpos[b+i] !== 16'(i)) begin n_fail++; $display("FAIL wild_pos%0d: got %0d want %0d", i, mpos[b+i], i); end
         end
         n_vec++; if (mcnt[b+2] !== 8'd3) begin n_fail++; $display("FAIL wild_cnt: got %0d want 3", mcnt[b+2]); end
      end
      jq = '{8'h02, 8'h2E, 8'h62, 8'h62, 8'h61, 8'h62};
      b = mpos.size();
      send_q(0);
      idle(3);
      n_vec++; if (mpos.size() - b != 1) begin n_fail++; $display("FAIL wild_lead_nmatch: got %0d want 1", mpos.size() - b); end
      if (mpos.size() - b >= 1) begin
         n_vec++; if (mpos[b] !== 16'd1) begin n_fail++; $display("FAIL wild_lead_pos: got %0d want 1", mpos[b]); end
      end
   endtask

   task automatic test_header_err();
      int b, bd;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) jq = '{8'h00, 8'h01, 8'h2E, 8'h41};
         else if (k == 1) jq = '{8'h09, 8'h02, 8'h61, 8'h62};
         else jq = '{8'h03, 8'h61, 8'h62};
         b = mpos.size(); bd = done_n;
         send_q(0);
         idle(3);
         n_vec++; if (mpos.size() != b) begin n_fail++; $display("FAIL hdr%0d_no_match: got %0d want 0", k, mpos.size() - b); end
         n_vec++; if (done_n - bd != 1) begin n_fail++; $display("FAIL hdr%0d_done_cnt: got %0d want 1", k, done_n - bd); end
         if (derr.size() > 0) begin
            n_vec++; if (derr[derr.size()-1] !== 1'b1) begin n_fail++; $display("FAIL hdr%0d_err_at_done: got %b want 1", k, derr[derr.size()-1]); end
         end
         n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL hdr%0d_err_held: got %b want 1", k, err); end
      end
   endtask

   task automatic test_gaps();
      int rl, rb;
      rl = ready_low; rb = ready_bad;
      test_basic(1, "gaps");
      n_vec++; if (ready_low - rl != 1) begin n_fail++; $display("FAIL gaps_ready_low: got %0d want 1", ready_low - rl); end
      n_vec++; if (ready_bad - rb != 0) begin n_fail++; $display("FAIL gaps_ready_vs_done: got %0d want 0", ready_bad - rb); end
   endtask

   task automatic test_saturate(input int nbytes, input string nm, input logic [15:0] last_pos);
      int b;
      b = mpos.size();
      jq = '{8'h01, 8'h2E};
      for (int i = 0; i < nbytes; i++) jq.push_back(8'(i));
      send_q(0);
      idle(3);
      n_vec++; if (mpos.size() - b != nbytes) begin n_fail++; $display("FAIL %s_nmatch: got %0d want %0d", nm, mpos.size() - b, nbytes); end
      if (mpos.size() - b == nbytes) begin
         n_vec++; if (mcnt[b+253] !== 8'd254) begin n_fail++; $display("FAIL %s_cnt254: got %0d want 254", nm, mcnt[b+253]); end
         n_vec++; if (mcnt[b+254] !== 8'd255) begin n_fail++; $display("FAIL %s_cnt255: got %0d want 255", nm, mcnt[b+254]); end
         n_vec++; if (mcnt[b+nbytes-1] !== 8'd255) begin n_fail++; $display("FAIL %s_cnt_last: got %0d want 255", nm, mcnt[b+nbytes-1]); end
         n_vec++; if (mpos[b+nbytes-1] !== last_pos) begin n_fail++; $display("FAIL %s_pos_last: got %0d want %0d", nm, mpos[b+nbytes-1], last_pos); end
         n_vec++; if (mpos[b+nbytes-2] !== last_pos - 16'd1) begin n_fail++; $display("FAIL %s_pos_prev: got %0d want %0d", nm, mpos[b+nbytes-2], last_pos - 16'd1); end
      end
      n_vec++; if (match_count !== 8'd255) begin n_fail++; $display("FAIL %s_count_held: got %0d want 255", nm, match_count); end
   endtask

   task automatic test_reset_mid();
      int b;
      jq = '{8'h02, 8'h61, 8'h62, 8'h61, 8'h62};
      for (int i = 0; i < jq.size(); i++) put(jq[i], 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h02; in_last = 1'b0;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
      n_vec++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_match_valid: got %b want 0", match_valid); end
      n_vec++; if (match_pos !== 16'd0) begin n_fail++; $display("FAIL rmid_match_pos: got %0d want 0", match_pos); end
      n_vec++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL rmid_match_count: got %0d want 0", match_count); end
      n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
      rst = 1'b0; in_valid = 1'b0;
      b = mpos.size();
      jq = '{8'h02, 8'h61, 8'h62, 8'h61, 8'h62};
      send_q(0);
      idle(3);
      n_vec++; if (mpos.size() - b != 1) begin n_fail++; $display("FAIL rmid_nmatch: got %0d want 1", mpos.size() - b); end
      if (mpos.size() - b >= 1) begin
         n_vec++; if (mpos[b] !== 16'd0) begin n_fail++; $display("FAIL rmid_pos: got %0d want 0", mpos[b]); end
         n_vec++; if (mcnt[b] !== 8'd1) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 1", mcnt[b]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic(0, "basic");
      test_wildcard();
      test_header_err();
      test_gaps();
      test_saturate(300, "sat", 16'd299);
      test_saturate(65537, "wrap", 16'd0);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
